// File: rtl/lcd_pkg.sv
// Shared types and constants for the board LCD serial transmitter.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_RST_LO,
    ST_RST_WAIT,
    ST_IDLE,
    ST_SHIFT,
    ST_CS_GAP
  } lcd_state_e;

  // Register-select values driven onto lcd_rs.
  localparam logic LCD_CMD = 1'b0;
  localparam logic LCD_DAT = 1'b1;

  // Default timing for the board panel.
  localparam int LCD_DATA_W     = 8;
  localparam int LCD_CLK_DIV    = 4;
  localparam int LCD_RST_CYCLES = 1000;
  localparam int LCD_RST_WAIT   = 1000;
  localparam int LCD_CS_IDLE    = 2;

  // Width of a counter able to hold the largest timing value without wrapping.
  function automatic int lcd_cnt_w(input int a, input int b, input int c,
                                   input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/lcd_bit_timer.sv
// Reloadable down-counter producing one tick per SCL half-period.
module lcd_bit_timer #(
  parameter int CLK_DIV = 4,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic tick,
  output logic tick_next
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // tick marks the last cycle of a half-period; tick_next predicts it one
  // cycle ahead for a free-running (not reloaded) counter.
  assign tick      = (cnt_q == '0);
  assign tick_next = (CLK_DIV == 1) || (cnt_q == CNT_W'(1));

  // Count down, reloading on request or after each tick.
  always_comb begin
    cnt_d = cnt_q - 1'b1;
    if (load || tick) cnt_d = RELOAD;
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= RELOAD;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/lcd_serial_tx.sv
// Write-only SPI-mode-0 transmitter for the board LCD with power-up reset sequencing.
module lcd_serial_tx
  import lcd_pkg::*;
#(
  parameter int DATA_W     = LCD_DATA_W,
  parameter int CLK_DIV    = LCD_CLK_DIV,
  parameter int RST_CYCLES = LCD_RST_CYCLES,
  parameter int RST_WAIT   = LCD_RST_WAIT,
  parameter int CS_IDLE    = LCD_CS_IDLE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_dc,
  output logic              init_done,
  output logic              busy,
  output logic              lcd_rst,
  output logic              lcd_rs,
  output logic              lcd_sd,
  output logic              lcd_scl,
  output logic              lcd_cs
);

  localparam int CNT_W = lcd_cnt_w(RST_CYCLES, RST_WAIT, CLK_DIV, DATA_W, CS_IDLE);

  lcd_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic scl_q, scl_d, sd_q, sd_d, rs_q, rs_d, cs_q, cs_d;
  logic lrst_q, lrst_d, ready_q, ready_d, done_q, done_d, busy_q, busy_d;
  logic load_word, tmr_tick, tmr_tick_next, hs;

  assign hs = s_valid && ready_q;

  lcd_bit_timer #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (load_word),
    .tick      (tmr_tick),
    .tick_next (tmr_tick_next)
  );

  // Next-state and registered-output logic for the reset sequence and shifter.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    scl_d     = scl_q;
    sd_d      = sd_q;
    rs_d      = rs_q;
    cs_d      = cs_q;
    lrst_d    = lrst_q;
    load_word = 1'b0;

    case (state_q)
      ST_RST_LO: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          lrst_d  = 1'b1;
          cnt_d   = '0;
          state_d = (RST_WAIT == 0) ? ST_IDLE : ST_RST_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RST_WAIT: begin
        if (cnt_q == CNT_W'(RST_WAIT - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (hs) load_word = 1'b1;
      end
      ST_SHIFT: begin
        if (tmr_tick) begin
          if (!scl_q) begin
            scl_d = 1'b1;
          end else if (bit_q != '0) begin
            // Falling edge: present the next bit while SCL is low.
            scl_d   = 1'b0;
            sd_d    = shreg_q[DATA_W-1];
            shreg_d = shreg_q << 1;
            bit_d   = bit_q - 1'b1;
          end else if (hs) begin
            load_word = 1'b1;
          end else begin
            scl_d   = 1'b0;
            cs_d    = 1'b1;
            cnt_d   = '0;
            state_d = ST_CS_GAP;
          end
        end
      end
      ST_CS_GAP: begin
        if (cnt_q == CNT_W'(CS_IDLE - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_RST_LO;
    endcase

    // A new word starts its first low phase with its MSB already on SD.
    if (load_word) begin
      state_d = ST_SHIFT;
      cs_d    = 1'b0;
      rs_d    = s_dc;
      sd_d    = s_data[DATA_W-1];
      shreg_d = s_data << 1;
      scl_d   = 1'b0;
      bit_d   = CNT_W'(DATA_W - 1);
    end

    // Ready in IDLE, and in the final cycle of the last bit's high phase so a
    // following word can continue the burst without a CS gap.
    ready_d = (state_d == ST_IDLE) ||
              ((state_d == ST_SHIFT) && scl_d && (bit_d == '0) && tmr_tick_next);
    busy_d  = (state_d != ST_IDLE);
    done_d  = done_q || (state_d == ST_IDLE);
  end

  // Control and pin registers; reset forces the panel into its reset state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RST_LO;
      cnt_q   <= '0;
      bit_q   <= '0;
      scl_q   <= 1'b0;
      sd_q    <= 1'b0;
      rs_q    <= 1'b0;
      cs_q    <= 1'b1;
      lrst_q  <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      scl_q   <= scl_d;
      sd_q    <= sd_d;
      rs_q    <= rs_d;
      cs_q    <= cs_d;
      lrst_q  <= lrst_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Shift register holds only the not-yet-sent bits and needs no reset.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  assign s_ready   = ready_q;
  assign init_done = done_q;
  assign busy      = busy_q;
  assign lcd_rst   = lrst_q;
  assign lcd_rs    = rs_q;
  assign lcd_sd    = sd_q;
  assign lcd_scl   = scl_q;
  assign lcd_cs    = cs_q;

endmodule

// File: tb/tb_lcd_serial_tx.sv
// Directed bench for lcd_serial_tx: reset sequence, single word, burst, abort, wide word.
module tb_lcd_serial_tx;
  import lcd_pkg::*;

  logic       clk;
  logic       rst, s_valid, s_ready, s_dc, init_done, busy;
  logic [7:0] s_data;
  logic       lcd_rst, lcd_rs, lcd_sd, lcd_scl, lcd_cs;

  logic       rst_b, s_valid_b, s_ready_b, s_dc_b, init_done_b, busy_b;
  logic [8:0] s_data_b;
  logic       lcd_rst_b, lcd_rs_b, lcd_sd_b, lcd_scl_b, lcd_cs_b;

  int tests_run = 0;
  int tests_failed = 0;

  // Pin activity for DUT A.
  int          cs_run, last_run, rises, cs_falls;
  logic [63:0] bits, rsv;
  logic        scl_prev, cs_prev;
  // Pin activity for DUT B.
  int          cs_run_b, last_run_b, rises_b, same_b;
  logic [63:0] bits_b, rsv_b;
  logic        scl_prev_b, cs_prev_b;

  lcd_serial_tx #(
    .DATA_W(8), .CLK_DIV(2), .RST_CYCLES(10), .RST_WAIT(5), .CS_IDLE(2)
  ) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_dc(s_dc), .init_done(init_done), .busy(busy), .lcd_rst(lcd_rst),
    .lcd_rs(lcd_rs), .lcd_sd(lcd_sd), .lcd_scl(lcd_scl), .lcd_cs(lcd_cs)
  );

  lcd_serial_tx #(
    .DATA_W(9), .CLK_DIV(1), .RST_CYCLES(10), .RST_WAIT(5), .CS_IDLE(2)
  ) dut_b (
    .clk(clk), .rst(rst_b), .s_valid(s_valid_b), .s_ready(s_ready_b), .s_data(s_data_b),
    .s_dc(s_dc_b), .init_done(init_done_b), .busy(busy_b), .lcd_rst(lcd_rst_b),
    .lcd_rs(lcd_rs_b), .lcd_sd(lcd_sd_b), .lcd_scl(lcd_scl_b), .lcd_cs(lcd_cs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    cs_run = 0; last_run = 0; rises = 0; cs_falls = 0; bits = '0; rsv = '0;
    scl_prev = lcd_scl; cs_prev = lcd_cs;
    cs_run_b = 0; last_run_b = 0; rises_b = 0; same_b = 0; bits_b = '0; rsv_b = '0;
    scl_prev_b = lcd_scl_b; cs_prev_b = lcd_cs_b;
  endtask

  // Advance to the next falling clock edge and record pin activity.
  task automatic tick();
    @(negedge clk);
    if (!lcd_cs) cs_run++;
    else if (cs_run != 0) begin last_run = cs_run; cs_run = 0; end
    if (!lcd_cs && cs_prev) cs_falls++;
    if (lcd_scl && !scl_prev) begin
      rises++; bits = {bits[62:0], lcd_sd}; rsv = {rsv[62:0], lcd_rs};
    end
    cs_prev = lcd_cs; scl_prev = lcd_scl;

    if (!lcd_cs_b) cs_run_b++;
    else if (cs_run_b != 0) begin last_run_b = cs_run_b; cs_run_b = 0; end
    if (!lcd_cs_b && !cs_prev_b && (lcd_scl_b == scl_prev_b)) same_b++;
    if (lcd_scl_b && !scl_prev_b) begin
      rises_b++; bits_b = {bits_b[62:0], lcd_sd_b}; rsv_b = {rsv_b[62:0], lcd_rs_b};
    end
    cs_prev_b = lcd_cs_b; scl_prev_b = lcd_scl_b;
  endtask

  // Offer a word; returns on the cycle after the handshake edge.
  task automatic send(input string tag, input logic [7:0] d, input logic dc, input bit hold);
    bit ok;
    ok = 1'b0;
    s_valid = 1'b1; s_data = d; s_dc = dc;
    for (int i = 0; i < 200; i++) begin
      if (s_ready) begin ok = 1'b1; tick(); break; end
      tick();
    end
    if (!hold) s_valid = 1'b0;
    check(tag, ok, 1'b1);
  endtask

  task automatic wait_cs_high(input string tag, input int max);
    for (int i = 0; i < max && lcd_cs == 1'b0; i++) tick();
    check(tag, lcd_cs, 1'b1);
  endtask

  initial begin
    int  n;
    bit  gap_bad;
    bit  ok;
    rst = 1'b1; s_valid = 1'b1; s_data = 8'h01; s_dc = LCD_DAT;
    rst_b = 1'b1; s_valid_b = 1'b0; s_data_b = '0; s_dc_b = LCD_CMD;
    clear_stats();
    repeat (3) tick();
    // {lcd_rst, lcd_cs, lcd_scl, lcd_sd, lcd_rs, s_ready, init_done, busy}
    check("reset_pins", {lcd_rst, lcd_cs, lcd_scl, lcd_sd, lcd_rs, s_ready, init_done, busy},
          8'b0100_0001);

    // Reset sequence with a word already pending (0x01 data).
    rst = 1'b0; rst_b = 1'b0;
    clear_stats();
    #1;
    for (int k = 0; k <= 15; k++) begin
      if (k > 0) tick();
      check($sformatf("rstseq_c%0d", k), {lcd_rst, init_done, s_ready, lcd_cs, lcd_scl},
            {(k >= 10), (k >= 15), (k >= 15), 1'b1, 1'b0});
    end
    tick();
    s_valid = 1'b0;
    check("pend_cs_low_c16", {lcd_cs, s_ready, busy}, 3'b001);
    wait_cs_high("pend_done", 100);
    check("pend_len", last_run, 32);
    check("pend_bits", bits[7:0], 8'h01);
    check("pend_rs", rsv[7:0], 8'hFF);
    repeat (40) tick();
    check("pend_rises", rises, 8);
    check("pend_single", cs_falls, 1);

    // Single command 0x2A.
    clear_stats();
    send("cmd_hs", 8'h2A, LCD_CMD, 1'b0);
    check("cmd_start", {lcd_cs, lcd_scl, lcd_sd, lcd_rs, busy, s_ready}, 6'b000010);
    s_data = 8'hFF; s_dc = LCD_DAT;
    wait_cs_high("cmd_done", 100);
    check("cmd_len", last_run, 32);
    check("cmd_rises", rises, 8);
    check("cmd_bits", bits[7:0], 8'h2A);
    check("cmd_rs", rsv[7:0], 8'h00);
    n = 0; gap_bad = 1'b0;
    while (!s_ready && n < 20) begin
      if (lcd_cs !== 1'b1 || lcd_scl !== 1'b0) gap_bad = 1'b1;
      tick(); n++;
    end
    check("cmd_gap_len", n, 2);
    check("cmd_gap_pins", gap_bad, 1'b0);

    // Burst 0x2C (command) then 0xFF (data) with s_valid held.
    repeat (3) tick();
    clear_stats();
    send("burst_hs0", 8'h2C, LCD_CMD, 1'b1);
    s_data = 8'hFF; s_dc = LCD_DAT;
    send("burst_hs1", 8'hFF, LCD_DAT, 1'b0);
    check("burst_c32", {lcd_cs, lcd_scl, lcd_rs, lcd_sd}, 4'b0011);
    check("burst_rises_c32", rises, 8);
    wait_cs_high("burst_done", 100);
    check("burst_len", last_run, 64);
    check("burst_falls", cs_falls, 1);
    check("burst_rises", rises, 16);
    check("burst_bits", bits[15:0], 16'h2CFF);
    check("burst_rs", rsv[15:0], 16'h00FF);
    for (int i = 0; i < 20 && !s_ready; i++) tick();
    check("burst_idle", s_ready, 1'b1);

    // Abort 0xA5 after three bits.
    clear_stats();
    send("abort_hs", 8'hA5, LCD_DAT, 1'b0);
    repeat (11) tick();
    check("abort_rises", rises, 3);
    check("abort_bits", bits[2:0], 3'b101);
    #2 rst = 1'b1;
    #1;
    check("abort_pins", {lcd_cs, lcd_scl, lcd_rst, init_done, s_ready, busy, lcd_sd, lcd_rs},
          8'b1000_0100);
    repeat (2) tick();
    rst = 1'b0;
    clear_stats();
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 9)  check("abort_rst_c9",  lcd_rst, 1'b0);
      if (k == 10) check("abort_rst_c10", lcd_rst, 1'b1);
      if (k == 14) check("abort_rdy_c14", {s_ready, init_done}, 2'b00);
      if (k == 15) check("abort_rdy_c15", {s_ready, init_done}, 2'b11);
    end
    repeat (20) tick();
    check("abort_no_resid", {rises, cs_falls}, 64'd0);

    // Nine-bit word on the CLK_DIV=1 instance.
    check("b_ready_state", {init_done_b, busy_b, lcd_rst_b, s_ready_b}, 4'b1011);
    clear_stats();
    s_valid_b = 1'b1; s_data_b = 9'h1FF; s_dc_b = LCD_DAT;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (s_ready_b) begin ok = 1'b1; tick(); break; end
      tick();
    end
    s_valid_b = 1'b0;
    check("b_hs", ok, 1'b1);
    for (int i = 0; i < 100 && lcd_cs_b == 1'b0; i++) tick();
    check("b_done", lcd_cs_b, 1'b1);
    check("b_len", last_run_b, 18);
    check("b_rises", rises_b, 9);
    check("b_bits", bits_b[8:0], 9'h1FF);
    check("b_rs", rsv_b[8:0], 9'h1FF);
    check("b_toggle", same_b, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
